// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the single-wire serial bus (master and slave sides).
// Parity framing is enabled by defining SERIAL_BUS_MASTER_PARITY_EN.
package serial_bus_pkg;

    localparam int DEF_ADDRESS_WIDTH = 12;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_TIMEOUT       = 64;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

`ifdef SERIAL_BUS_MASTER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_START,
        ST_ADDR,
        ST_RW,
        ST_WDATA,
        ST_TX_PAR,
        ST_WAIT_WR,
        ST_RD_WAIT,
        ST_RDATA,
        ST_RX_PAR
    } bus_state_e;

    // Bits the master drives for one frame: start, address, direction, data, parity.
    function automatic int frame_len(input int aw, input int dw, input bit is_read);
        return 1 + aw + 1 + (is_read ? 0 : dw) + PARITY_BITS;
    endfunction

endpackage

// File: rtl/serial_shift_tx.sv
// Parallel-load LSB-first shifter; done_o is high while the final bit is presented.
module serial_shift_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         shift_i,
    output logic         bit_o,
    output logic         done_o
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  sh_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sh_q  <= data_i;
            cnt_q <= '0;
        end else if (shift_i) begin
            sh_q  <= sh_q >> 1;
            cnt_q <= (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign bit_o  = sh_q[0];
    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_bus_master.sv
// Initiator of the single-wire serial bus: arbitrates, sends a frame, collects the reply.
// Optional even parity framing: SERIAL_BUS_MASTER_PARITY_EN.
module serial_bus_master
    import serial_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req,
    input  logic                     rd_wrt,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     bus_grant,
    output logic                     bus_request,
    output logic                     bus_util,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     done,
    output logic                     timeout,
    output logic                     master_busy,
    inout  wire                      data_bus_serial,
    inout  wire                      slave_busy
);

    localparam int CNT_MAX = (TIMEOUT > DATA_WIDTH) ? TIMEOUT : DATA_WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RX_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);

    bus_state_e state_q;

    logic                  rw_q;
    logic                  par_q;
    logic                  guard_q;
    logic                  util_q;
    logic                  breq_q;
    logic                  done_q;
    logic                  to_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [DATA_WIDTH-1:0] rsh_q;
    logic [DATA_WIDTH-1:0] rsh_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic line_in;
    logic busy_in;
    logic tx_bit;
    logic load;
    logic tx_par;
    logic a_bit;
    logic a_done;
    logic w_bit;
    logic w_done;

    assign line_in = data_bus_serial;
    assign busy_in = slave_busy;

    assign slave_busy      = 1'bz;
    assign data_bus_serial = util_q ? tx_bit : 1'bz;

    assign load   = (state_q == ST_IDLE) && req;
    assign tx_par = (^{addr, rd_wrt}) ^ (^(wdata & {DATA_WIDTH{~rd_wrt}}));
    assign cnt_d  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    assign rsh_d  = {line_in, rsh_q[DATA_WIDTH-1:1]};

    serial_shift_tx #(
        .W (ADDRESS_WIDTH)
    ) u_addr_tx (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (load),
        .data_i  (addr),
        .shift_i (state_q == ST_ADDR),
        .bit_o   (a_bit),
        .done_o  (a_done)
    );

    serial_shift_tx #(
        .W (DATA_WIDTH)
    ) u_wdata_tx (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (load),
        .data_i  (wdata),
        .shift_i (state_q == ST_WDATA),
        .bit_o   (w_bit),
        .done_o  (w_done)
    );

    always_comb begin
        tx_bit = LINE_IDLE;
        case (state_q)
            ST_START:  tx_bit = START_BIT;
            ST_ADDR:   tx_bit = a_bit;
            ST_RW:     tx_bit = rw_q;
            ST_WDATA:  tx_bit = w_bit;
            ST_TX_PAR: tx_bit = par_q;
            default:   tx_bit = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            par_q   <= 1'b0;
            guard_q <= 1'b0;
            util_q  <= 1'b0;
            breq_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            rsh_q   <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            to_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        rw_q    <= rd_wrt;
                        par_q   <= tx_par;
                        breq_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_grant) begin
                        util_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    state_q <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (a_done) begin
                        state_q <= ST_RW;
                    end
                end
                ST_RW: begin
                    if (!rw_q) begin
                        state_q <= ST_WDATA;
                    end else begin
`ifdef SERIAL_BUS_MASTER_PARITY_EN
                        state_q <= ST_TX_PAR;
`else
                        util_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_RD_WAIT;
`endif
                    end
                end
                ST_WDATA: begin
                    if (w_done) begin
`ifdef SERIAL_BUS_MASTER_PARITY_EN
                        state_q <= ST_TX_PAR;
`else
                        util_q  <= 1'b0;
                        cnt_q   <= '0;
                        guard_q <= 1'b1;
                        state_q <= ST_WAIT_WR;
`endif
                    end
                end
                ST_TX_PAR: begin
                    util_q  <= 1'b0;
                    cnt_q   <= '0;
                    guard_q <= 1'b1;
                    state_q <= rw_q ? ST_RD_WAIT : ST_WAIT_WR;
                end
                // Slave may still be turning the line around; skip its first busy sample.
                ST_WAIT_WR: begin
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!busy_in) begin
                        done_q  <= 1'b1;
                        breq_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        to_q    <= 1'b1;
                        breq_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RD_WAIT: begin
                    if (line_in != LINE_IDLE) begin
                        cnt_q   <= '0;
                        state_q <= ST_RDATA;
                    end else if (cnt_q == TO_LAST) begin
                        to_q    <= 1'b1;
                        breq_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RDATA: begin
                    rsh_q <= rsh_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == RX_LAST) begin
`ifdef SERIAL_BUS_MASTER_PARITY_EN
                        state_q <= ST_RX_PAR;
`else
                        rdata_q <= rsh_d;
                        done_q  <= 1'b1;
                        breq_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end
                end
                ST_RX_PAR: begin
                    breq_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (line_in == ^rsh_q) begin
                        rdata_q <= rsh_q;
                        done_q  <= 1'b1;
                    end else begin
                        to_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_request = breq_q;
    assign bus_util    = util_q;
    assign rdata       = rdata_q;
    assign done        = done_q;
    assign timeout     = to_q;
    assign master_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_bus_master.sv
// Bench for serial_bus_master: frame-level reference model, directed and random transactions.
`timescale 1ns/1ps
module tb_serial_bus_master;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 64;
`ifdef SERIAL_BUS_MASTER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req = 1'b0;
    logic          rd_wrt = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          bus_grant = 1'b0;
    logic          bus_request;
    logic          bus_util;
    logic [DW-1:0] rdata;
    logic          done;
    logic          timeout;
    logic          master_busy;
    wire           data_bus_serial;
    wire           slave_busy;

    logic sl_en = 1'b0;
    logic sl_bit = 1'b1;
    logic sb_val = 1'b0;

    // Slave drive, otherwise the bus pull-up level when nobody drives.
    assign data_bus_serial = sl_en ? sl_bit : (bus_util ? 1'bz : 1'b1);
    assign slave_busy      = sb_val;

    serial_bus_master dut (
        .clk             (clk),
        .rstn            (rstn),
        .req             (req),
        .rd_wrt          (rd_wrt),
        .addr            (addr),
        .wdata           (wdata),
        .bus_grant       (bus_grant),
        .bus_request     (bus_request),
        .bus_util        (bus_util),
        .rdata           (rdata),
        .done            (done),
        .timeout         (timeout),
        .master_busy     (master_busy),
        .data_bus_serial (data_bus_serial),
        .slave_busy      (slave_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;
    logic [DW-1:0] m_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rdel < 0 means the slave never answers a read.
    task automatic do_txn(input string tag, input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int gdel, input int busy,
                          input int rdel, input logic [DW-1:0] rd, input bit bad_par,
                          input bit extra);
        int frame, rdw, cap, g, k, r, first_k, nbits, exp_k, got_k;
        logic [63:0] exp_bits, got_bits;
        logic [DW-1:0] wmask;
        bit exp_done, got_done, got_to, seen, got_breq, any;
        logic [DW-1:0] got_rdata;

        frame = 1 + AW + 1 + (rw ? 0 : DW) + PAR;
        rdw = 1 + AW + 1 + PAR;
        wmask = rw ? '0 : wd;
        exp_bits = '0;
        for (int i = 0; i < AW; i++) exp_bits[1+i] = a[i];
        exp_bits[1+AW] = rw;
        if (!rw) for (int i = 0; i < DW; i++) exp_bits[2+AW+i] = wd[i];
        if (PAR == 1) exp_bits[frame-1] = ^{a, rw, wmask};

        if (!rw) begin
            exp_done = (busy < TO);
            exp_k = frame + 2 + ((busy < TO) ? busy : TO - 1);
        end else if (rdel < 0) begin
            exp_done = 1'b0;
            exp_k = rdw + TO;
        end else begin
            exp_done = !bad_par;
            exp_k = rdw + rdel + DW + 1 + PAR;
        end

        @(posedge clk); #1;
        rd_wrt = rw; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        rd_wrt = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
        cap = cyc;
        g = cap + gdel + 1;
        seen = 0; nbits = 0; got_bits = '0; first_k = -1;
        got_k = -1; got_done = 0; got_to = 0; got_breq = 1; got_rdata = '0;

        for (int t = 0; t < 400; t++) begin
            k = cyc - g;
            if (cyc - cap >= gdel) bus_grant = 1'b1;
            req = extra && (k == 5);
            if (!rw) begin
                sb_val = (k + 1 >= frame + 2) && (k + 1 < frame + 2 + busy);
            end else begin
                sl_en = 1'b0; sl_bit = 1'b1;
                if (rdel >= 0) begin
                    r = k - rdw - rdel;
                    if (r == 0) begin
                        sl_en = 1'b1; sl_bit = 1'b0;
                    end else if (r >= 1 && r <= DW) begin
                        sl_en = 1'b1; sl_bit = rd[r-1];
                    end else if (PAR == 1 && r == DW + 1) begin
                        sl_en = 1'b1; sl_bit = (^rd) ^ bad_par;
                    end
                end
            end
            @(negedge clk);
            if (bus_util) begin
                if (first_k < 0) first_k = k;
                if (nbits < 64) got_bits[nbits] = data_bus_serial;
                nbits++;
            end
            if (done || timeout) begin
                seen = 1; got_k = k; got_done = done; got_to = timeout;
                got_breq = bus_request; got_rdata = rdata;
                break;
            end
            @(posedge clk); #1;
        end

        req = 1'b0; sl_en = 1'b0; sb_val = 1'b0;
        if (rw && exp_done) m_rdata = rd;
        check({tag, "_event"}, 64'(seen), 64'd1);
        check({tag, "_outcome"}, {got_done, got_to}, exp_done ? 2'b10 : 2'b01);
        check({tag, "_cycle"}, 64'(got_k), 64'(exp_k));
        check({tag, "_first"}, 64'(first_k), 64'd0);
        check({tag, "_nbits"}, 64'(nbits), 64'(frame));
        check({tag, "_bits"}, got_bits, exp_bits);
        check({tag, "_breq"}, 64'(got_breq), 64'd0);
        check({tag, "_rdata"}, got_rdata, m_rdata);

        @(posedge clk); #1;
        bus_grant = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {master_busy, done, timeout, bus_util}, 4'b0);
        if (extra) begin
            any = 0;
            repeat (40) begin
                @(negedge clk);
                any |= bus_request | master_busy;
            end
            check({tag, "_dropped"}, 64'(any), 64'd0);
        end
    endtask

    initial begin
        int gd, bz, rdl;
        logic rwr;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {bus_request, bus_util, done, timeout, master_busy}, 5'b0);
        check("rst_rdata", rdata, 0);
        check("rst_line", data_bus_serial, 1);
        rstn = 1'b1;

        do_txn("wr_basic", 1'b0, 12'h0A5, 8'h3C, 0, 0, 0, 8'h00, 0, 0);
        do_txn("rd_basic", 1'b1, 12'h7FF, 8'h00, 0, 0, 5, 8'hA5, 0, 0);
        do_txn("rd_silent", 1'b1, 12'h123, 8'h00, 0, 0, -1, 8'h00, 0, 0);
        do_txn("wr_busy10", 1'b0, 12'h456, 8'hC3, 0, 10, 0, 8'h00, 0, 0);
        do_txn("wr_busy100", 1'b0, 12'h9E1, 8'h81, 0, 100, 0, 8'h00, 0, 0);
        do_txn("gdel_extra", 1'b0, 12'h3F0, 8'h5A, 20, 0, 0, 8'h00, 0, 1);

        @(posedge clk); #1;
        rd_wrt = 1'b0; addr = 12'hABC; wdata = 8'h77; req = 1'b1; bus_grant = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_mid", {bus_util, bus_request, master_busy}, 3'b111);
        rstn = 1'b0;
        #1;
        m_rdata = '0;
        check("rst_mid_outs", {bus_request, bus_util, done, timeout, master_busy}, 5'b0);
        check("rst_mid_rdata", rdata, m_rdata);
        check("rst_mid_line", data_bus_serial, 1);
        @(posedge clk); #1;
        rstn = 1'b1; bus_grant = 1'b0;

        do_txn("post_rst", 1'b0, 12'hABC, 8'h77, 0, 0, 0, 8'h00, 0, 0);
`ifdef SERIAL_BUS_MASTER_PARITY_EN
        do_txn("rd_badpar", 1'b1, 12'h2D4, 8'h00, 0, 0, 3, 8'h5A, 1, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            rwr = 1'($urandom);
            gd = $urandom_range(0, 5);
            bz = ($urandom_range(0, 3) == 0) ? 80 : $urandom_range(0, 12);
            rdl = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 20);
            do_txn("rand", rwr, AW'($urandom), DW'($urandom), gd, bz, rdl, DW'($urandom), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
